// File: rtl/mem_access_unit_if.sv
// Request/response and DRAM word-port bundle for the data-memory access unit.
// The master side is the pipeline plus the DRAM. The slave side is the access unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dram_we;
  logic [31:0] dram_adr;
  logic [31:0] dram_wdin;
  logic [31:0] dram_rd;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dram_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, dram_we, dram_adr, dram_wdin
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dram_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, dram_we, dram_adr, dram_wdin
  );
endinterface

// File: rtl/mem_access_unit.sv
// Turns RV32I load/store requests into 32-bit word accesses on DRAM.
// Sub-word stores use a read-modify-write sequence.
module mem_access_unit #(
  parameter int ADDR_W = 16
) (
  input logic             clk,
  input logic             rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] adr_q;
  logic [31:0] wdin_q;

  logic        accept;
  logic        req_err;
  logic        rmw;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign accept = bus.req_valid && (state == IDLE);
  assign rmw    = we_q && (f3_q != 3'b010);

  // Misalignment, illegal encodings and out-of-range addresses are all rejected up front.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = |bus.req_addr[1:0];
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (|bus.req_addr[31:ADDR_W])
      req_err = 1'b1;
  end

  always_comb begin
    lane_b    = bus.dram_rd[{lane_q, 3'b000} +: 8];
    lane_h    = lane_q[1] ? bus.dram_rd[31:16] : bus.dram_rd[15:0];
    merge_val = bus.dram_rd;
    if (f3_q == 3'b000)
      merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merge_val[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    case (f3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'd0, lane_b};
      3'b101:  load_val = {16'd0, lane_h};
      default: load_val = bus.dram_rd;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:  state_nxt = rmw ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The write strobe is masked by reset so an interrupted RMW never lands in DRAM.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.dram_we    = 1'b0;
    if (!rst && ((state == ACCESS && we_q && !rmw) || state == WRITE))
      bus.dram_we = 1'b1;
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.dram_adr   = adr_q;
  assign bus.dram_wdin  = wdin_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
      wdata_q <= 16'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      adr_q   <= 32'd0;
      wdin_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        lane_q  <= bus.req_addr[1:0];
        wdata_q <= bus.req_wdata[15:0];
        if (req_err) begin
          err_q   <= 1'b1;
          rdata_q <= 32'd0;
        end else begin
          adr_q <= {bus.req_addr[31:2], 2'b00};
          if (bus.req_we && bus.req_funct3 == 3'b010)
            wdin_q <= bus.req_wdata;
        end
      end
      if (state == ACCESS) begin
        err_q <= 1'b0;
        if (!we_q)
          rdata_q <= load_val;
        else if (rmw)
          wdin_q <= merge_val;
      end
    end
  end

endmodule
